// File: rtl/enc_slot_ctrl_if.sv
// Slot bus between a host and the rotary-encoder slot controller.
// The host drives select/strobes/address/data; the slot returns read data and its interrupt.
interface enc_slot_ctrl_if;
  logic        cs;
  logic        read;
  logic        write;
  logic [4:0]  addr;
  logic [31:0] wr_data;
  logic [31:0] rd_data;
  logic        irq;

  modport master (
    output cs, read, write, addr, wr_data,
    input  rd_data, irq
  );

  modport slave (
    input  cs, read, write, addr, wr_data,
    output rd_data, irq
  );
endinterface

// File: rtl/enc_slot_ctrl.sv
// Rotary-encoder slot: synchronizes A/B/button/switch, decodes detents with a Gray FSM,
// tracks a bounded position counter and exposes it through a small register map.
module enc_slot_ctrl #(
  parameter int W           = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic           clk,
  input  logic           reset,
  enc_slot_ctrl_if.slave bus,
  input  logic [3:0]     enc
);

  localparam logic [4:0]   ADDR_POS    = 5'd0;
  localparam logic [4:0]   ADDR_CTRL   = 5'd1;
  localparam logic [4:0]   ADDR_MAX    = 5'd2;
  localparam logic [4:0]   ADDR_STATUS = 5'd3;
  localparam logic [4:0]   ADDR_ERRCNT = 5'd4;
  localparam logic [4:0]   ADDR_IRQEN  = 5'd5;
  localparam logic [W-1:0] ZERO_W      = {W{1'b0}};
  localparam logic [W-1:0] ONE_W       = {{(W-1){1'b0}}, 1'b1};
  localparam logic [W-1:0] MAX_RST     = {W{1'b1}};

  typedef enum logic [1:0] {
    AB_00 = 2'b00,
    AB_01 = 2'b01,
    AB_11 = 2'b11,
    AB_10 = 2'b10
  } ab_state_e;

  logic [3:0]   sync_r [SYNC_STAGES];
  logic [3:0]   enc_s;
  logic [1:0]   ab_s;
  ab_state_e    state_r;
  ab_state_e    state_next_s;
  logic         armed_r;
  logic         armed_next_s;
  logic         raw_cw_s;
  logic         raw_ccw_s;
  logic         illegal_s;
  logic         step_up_r;
  logic         step_dn_r;
  logic [W-1:0] pos_r;
  logic [W-1:0] max_r;
  logic [2:0]   ctrl_r;
  logic [3:0]   status_r;
  logic [3:0]   irq_en_r;
  logic [7:0]   errcnt_r;
  logic         btn_prev_r;
  logic         irq_r;
  logic         btn_rise_s;
  logic         wr_en_s;
  logic         wr_pos_s;
  logic         wr_ctrl_s;
  logic         wr_max_s;
  logic         wr_sts_s;
  logic         wr_err_s;
  logic         wr_irqen_s;
  logic [W-1:0] wr_val_s;
  logic [W-1:0] pos_step_s;
  logic [W-1:0] pos_next_s;
  logic [3:0]   step_set_s;
  logic [3:0]   set_s;
  logic [3:0]   status_next_s;
  logic [31:0]  rd_data_s;
  logic         unused_s;

  // Input synchronizer chain for all four encoder lines.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < SYNC_STAGES; i++) begin
        sync_r[i] <= 4'b0000;
      end
    end else begin
      sync_r[0] <= enc;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        sync_r[i] <= sync_r[i-1];
      end
    end
  end

  assign enc_s      = sync_r[SYNC_STAGES-1];
  assign ab_s       = {enc_s[0], enc_s[1]};
  assign btn_rise_s = enc_s[2] & ~btn_prev_r;

  // Gray decoder: always adopts the sampled AB; steps only once a detent has left 00 since reset.
  always_comb begin
    state_next_s = ab_state_e'(ab_s);
    armed_next_s = armed_r;
    raw_cw_s     = 1'b0;
    raw_ccw_s    = 1'b0;
    illegal_s    = 1'b0;
    case (state_r)
      AB_00: begin
        illegal_s = (ab_s == 2'b11);
        if ((ab_s == 2'b01) || (ab_s == 2'b10)) begin
          armed_next_s = 1'b1;
        end else begin
          armed_next_s = armed_r;
        end
      end
      AB_01: begin
        illegal_s = (ab_s == 2'b10);
        raw_ccw_s = armed_r && (ab_s == 2'b00);
      end
      AB_11: begin
        illegal_s = (ab_s == 2'b00);
      end
      AB_10: begin
        illegal_s = (ab_s == 2'b01);
        raw_cw_s  = armed_r && (ab_s == 2'b00);
      end
      default: begin
        state_next_s = AB_00;
        armed_next_s = 1'b0;
      end
    endcase
  end

  // Decoder state and the registered, direction-resolved step pulses.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r   <= AB_00;
      armed_r   <= 1'b0;
      step_up_r <= 1'b0;
      step_dn_r <= 1'b0;
    end else begin
      state_r   <= state_next_s;
      armed_r   <= armed_next_s;
      step_up_r <= ctrl_r[0] & (ctrl_r[2] ? raw_ccw_s : raw_cw_s);
      step_dn_r <= ctrl_r[0] & (ctrl_r[2] ? raw_cw_s : raw_ccw_s);
    end
  end

  assign wr_en_s    = bus.cs & bus.write;
  assign wr_pos_s   = wr_en_s & (bus.addr == ADDR_POS);
  assign wr_ctrl_s  = wr_en_s & (bus.addr == ADDR_CTRL);
  assign wr_max_s   = wr_en_s & (bus.addr == ADDR_MAX);
  assign wr_sts_s   = wr_en_s & (bus.addr == ADDR_STATUS);
  assign wr_err_s   = wr_en_s & (bus.addr == ADDR_ERRCNT);
  assign wr_irqen_s = wr_en_s & (bus.addr == ADDR_IRQEN);
  assign wr_val_s   = bus.wr_data[W-1:0];

  // Position update: host POS write beats a step; a lowered MAX drags POS down with it.
  always_comb begin
    pos_step_s = pos_r;
    step_set_s = 4'b0000;
    if (step_up_r) begin
      if (pos_r >= max_r) begin
        step_set_s[3] = 1'b1;
        if (ctrl_r[1]) begin
          pos_step_s    = ZERO_W;
          step_set_s[0] = 1'b1;
        end else begin
          pos_step_s = max_r;
        end
      end else begin
        pos_step_s    = pos_r + ONE_W;
        step_set_s[0] = 1'b1;
      end
    end else if (step_dn_r) begin
      if (pos_r == ZERO_W) begin
        step_set_s[3] = 1'b1;
        if (ctrl_r[1]) begin
          pos_step_s    = max_r;
          step_set_s[1] = 1'b1;
        end else begin
          pos_step_s = ZERO_W;
        end
      end else begin
        pos_step_s    = pos_r - ONE_W;
        step_set_s[1] = 1'b1;
      end
    end else begin
      pos_step_s = pos_r;
    end

    if (wr_pos_s) begin
      pos_next_s = (wr_val_s > max_r) ? max_r : wr_val_s;
      set_s      = {1'b0, btn_rise_s, 2'b00};
    end else begin
      pos_next_s = (wr_max_s && (pos_step_s > wr_val_s)) ? wr_val_s : pos_step_s;
      set_s      = step_set_s | {1'b0, btn_rise_s, 2'b00};
    end
  end

  // Hardware set is OR-ed in after the W1C mask so it wins a same-edge clear.
  assign status_next_s = (wr_sts_s ? (status_r & ~bus.wr_data[3:0]) : status_r) | set_s;

  // Register file, error counter, button edge tracker and interrupt flop.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pos_r      <= ZERO_W;
      max_r      <= MAX_RST;
      ctrl_r     <= 3'b001;
      status_r   <= 4'b0000;
      irq_en_r   <= 4'b0000;
      errcnt_r   <= 8'h00;
      btn_prev_r <= 1'b0;
      irq_r      <= 1'b0;
    end else begin
      pos_r      <= pos_next_s;
      status_r   <= status_next_s;
      btn_prev_r <= enc_s[2];
      irq_r      <= |(status_r & irq_en_r);
      if (wr_max_s) begin
        max_r <= wr_val_s;
      end
      if (wr_ctrl_s) begin
        ctrl_r <= bus.wr_data[2:0];
      end
      if (wr_irqen_s) begin
        irq_en_r <= bus.wr_data[3:0];
      end
      if (wr_err_s) begin
        errcnt_r <= 8'h00;
      end else if (illegal_s && (errcnt_r != 8'hFF)) begin
        errcnt_r <= errcnt_r + 8'h01;
      end
    end
  end

  // Read mux: unmapped addresses and unused bits return zero.
  always_comb begin
    rd_data_s = 32'h0000_0000;
    case (bus.addr)
      ADDR_POS:    rd_data_s = {{(32-W){1'b0}}, pos_r};
      ADDR_CTRL:   rd_data_s = {29'h0000_0000, ctrl_r};
      ADDR_MAX:    rd_data_s = {{(32-W){1'b0}}, max_r};
      ADDR_STATUS: rd_data_s = {26'h000_0000, enc_s[3], enc_s[2], status_r};
      ADDR_ERRCNT: rd_data_s = {24'h00_0000, errcnt_r};
      ADDR_IRQEN:  rd_data_s = {28'h000_0000, irq_en_r};
      default:     rd_data_s = 32'h0000_0000;
    endcase
  end

  assign bus.rd_data = rd_data_s;
  assign bus.irq     = irq_r;

  // Reads have no side effects; upper write-data bits are don't-care.
  assign unused_s = bus.read ^ (^bus.wr_data);

endmodule

// File: tb/tb_enc_slot_ctrl.sv
// Directed plus randomized bench for enc_slot_ctrl, checked against an event-level
// model of the encoder rules and register map.
module tb_enc_slot_ctrl;
  localparam int W  = 16;
  localparam int SS = 2;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] enc;
  int         checks   = 0;
  int         failures = 0;

  logic [W-1:0] m_pos;
  logic [W-1:0] m_max;
  logic [2:0]   m_ctrl;
  logic [3:0]   m_status;
  logic [3:0]   m_irqen;
  int           m_err;
  logic [1:0]   m_ab;
  bit           m_armed;
  logic         m_btn;

  enc_slot_ctrl_if bus();

  enc_slot_ctrl #(.W(W), .SYNC_STAGES(SS)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus),
    .enc   (enc)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout required=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic bus_wr(input logic [4:0] a, input logic [31:0] d);
    @(negedge clk);
    bus.cs = 1'b1; bus.write = 1'b1; bus.addr = a; bus.wr_data = d;
    @(negedge clk);
    bus.cs = 1'b0; bus.write = 1'b0; bus.wr_data = 32'h0;
  endtask

  task automatic bus_rd(input logic [4:0] a, output logic [31:0] d);
    @(negedge clk);
    bus.cs = 1'b1; bus.read = 1'b1; bus.addr = a;
    #1;
    d = bus.rd_data;
    bus.cs = 1'b0; bus.read = 1'b0;
  endtask

  task automatic model_reset();
    m_pos = '0; m_max = {W{1'b1}}; m_ctrl = 3'b001; m_status = 4'h0;
    m_irqen = 4'h0; m_err = 0; m_ab = 2'b00; m_armed = 1'b0;
  endtask

  task automatic model_wr(input logic [4:0] a, input logic [31:0] d);
    case (a)
      5'd0: m_pos = (d[W-1:0] > m_max) ? m_max : d[W-1:0];
      5'd1: m_ctrl = d[2:0];
      5'd2: begin m_max = d[W-1:0]; if (m_pos > m_max) m_pos = m_max; end
      5'd3: m_status = m_status & ~d[3:0];
      5'd4: m_err = 0;
      5'd5: m_irqen = d[3:0];
      default: ;
    endcase
  endtask

  task automatic host_wr(input logic [4:0] a, input logic [31:0] d);
    bus_wr(a, d);
    model_wr(a, d);
  endtask

  // One applied step in the model: up = toward MAX.
  task automatic model_move(input bit up);
    if (up) begin
      if (m_pos == m_max) begin
        m_status[3] = 1'b1;
        if (m_ctrl[1]) begin m_pos = '0; m_status[0] = 1'b1; end
      end else begin
        m_pos = m_pos + 1'b1; m_status[0] = 1'b1;
      end
    end else begin
      if (m_pos == '0) begin
        m_status[3] = 1'b1;
        if (m_ctrl[1]) begin m_pos = m_max; m_status[1] = 1'b1; end
      end else begin
        m_pos = m_pos - 1'b1; m_status[1] = 1'b1;
      end
    end
  endtask

  // Encoder rules: double-bit change is an error; a CW detent ends 10->00, CCW ends 01->00.
  task automatic model_ab(input logic [1:0] nab);
    logic [1:0] d;
    bit cw, ccw;
    d = nab ^ m_ab; cw = 1'b0; ccw = 1'b0;
    if (d == 2'b11) begin
      if (m_err < 255) m_err++;
    end else if (d != 2'b00) begin
      if (m_ab == 2'b00) m_armed = 1'b1;
      if (nab == 2'b00 && m_armed) begin
        cw  = (m_ab == 2'b10);
        ccw = (m_ab == 2'b01);
      end
    end
    m_ab = nab;
    if (m_ctrl[0] && (cw || ccw)) model_move(cw ^ m_ctrl[2]);
  endtask

  task automatic drive_ab(input logic [1:0] ab);
    enc[0] = ab[1];
    enc[1] = ab[0];
  endtask

  task automatic set_ab(input logic [1:0] ab);
    @(negedge clk);
    drive_ab(ab);
    repeat (6) @(posedge clk);
    model_ab(ab);
  endtask

  task automatic cw_detent();
    set_ab(2'b01); set_ab(2'b11); set_ab(2'b10); set_ab(2'b00);
  endtask

  task automatic ccw_detent();
    set_ab(2'b10); set_ab(2'b11); set_ab(2'b01); set_ab(2'b00);
  endtask

  task automatic button(input logic level);
    @(negedge clk);
    enc[2] = level;
    repeat (6) @(posedge clk);
    if (level && !m_btn) m_status[2] = 1'b1;
    m_btn = level;
  endtask

  task automatic switch_set(input logic level);
    @(negedge clk);
    enc[3] = level;
    repeat (6) @(posedge clk);
  endtask

  task automatic check_all(input string tag);
    logic [31:0] d;
    bus_rd(5'd0, d); chk({tag, "_pos"}, d, {{(32-W){1'b0}}, m_pos});
    bus_rd(5'd3, d); chk({tag, "_status"}, d, {26'h0, enc[3], enc[2], m_status});
    bus_rd(5'd4, d); chk({tag, "_errcnt"}, d, 32'(m_err));
    chk({tag, "_irq"}, {31'h0, bus.irq}, {31'h0, |(m_status & m_irqen)});
  endtask

  task automatic chk_reset(input string tag);
    logic [31:0] d;
    bus_rd(5'd0, d); chk({tag, "_pos"}, d, 32'h0);
    bus_rd(5'd1, d); chk({tag, "_ctrl"}, d, 32'h1);
    bus_rd(5'd2, d); chk({tag, "_max"}, d, (32'd1 << W) - 32'd1);
    bus_rd(5'd3, d); chk({tag, "_status"}, d, 32'h0);
    bus_rd(5'd4, d); chk({tag, "_errcnt"}, d, 32'h0);
    bus_rd(5'd5, d); chk({tag, "_irqen"}, d, 32'h0);
    chk({tag, "_irq"}, {31'h0, bus.irq}, 32'h0);
  endtask

  initial begin
    logic [31:0] d;
    reset = 1'b0; enc = 4'h0; m_btn = 1'b0;
    bus.cs = 1'b0; bus.read = 1'b0; bus.write = 1'b0; bus.addr = 5'd0; bus.wr_data = 32'h0;
    model_reset();
    repeat (3) @(posedge clk);
    chk_reset("rst");
    @(negedge clk);
    reset = 1'b1;

    // Four CW detents; the last one also measures enc-to-POS latency.
    cw_detent(); cw_detent(); cw_detent();
    set_ab(2'b01); set_ab(2'b11); set_ab(2'b10);
    @(negedge clk);
    drive_ab(2'b00);
    repeat (SS + 1) @(posedge clk);
    bus_rd(5'd0, d); chk("lat_before", d, {{(32-W){1'b0}}, m_pos});
    model_ab(2'b00);
    bus_rd(5'd0, d); chk("lat_after", d, {{(32-W){1'b0}}, m_pos});
    check_all("cw4");

    // Saturation at MAX, then wrap.
    host_wr(5'd3, 32'hF);
    host_wr(5'd2, 32'd5);
    host_wr(5'd0, 32'd5);
    cw_detent();
    check_all("sat");
    host_wr(5'd1, 32'h3);
    cw_detent();
    check_all("wrap");
    ccw_detent();
    check_all("wrap_ccw");

    // Illegal jumps and counter saturation.
    host_wr(5'd1, 32'h1); host_wr(5'd2, 32'hFFFF); host_wr(5'd0, 32'd2); host_wr(5'd3, 32'hF);
    set_ab(2'b11);
    check_all("ill1");
    for (int i = 0; i < 256; i++) set_ab(m_ab ^ 2'b11);
    check_all("ill256");
    set_ab(2'b10); set_ab(2'b00);
    check_all("ill_back");
    host_wr(5'd4, 32'h1234);
    check_all("err_clr");

    // POS write coincident with a CW step, then MAX below POS.
    host_wr(5'd3, 32'hF);
    set_ab(2'b01); set_ab(2'b11); set_ab(2'b10);
    @(negedge clk);
    drive_ab(2'b00);
    repeat (SS + 1) @(posedge clk);
    @(negedge clk);
    bus.cs = 1'b1; bus.write = 1'b1; bus.addr = 5'd0; bus.wr_data = 32'h0009;
    @(negedge clk);
    bus.cs = 1'b0; bus.write = 1'b0; bus.wr_data = 32'h0;
    m_ab = 2'b00;
    model_wr(5'd0, 32'h0009);
    check_all("poswr_step");
    host_wr(5'd2, 32'd3);
    check_all("max_clamp");
    bus_rd(5'd2, d); chk("max_rd", d, 32'd3);

    // Button interrupt path.
    host_wr(5'd5, 32'h4);
    host_wr(5'd3, 32'hF);
    @(negedge clk);
    enc[2] = 1'b1;
    repeat (SS + 1) @(posedge clk);
    m_status[2] = 1'b1; m_btn = 1'b1;
    bus_rd(5'd3, d); chk("btn_status", d, {26'h0, enc[3], enc[2], m_status});
    chk("btn_irq_early", {31'h0, bus.irq}, 32'h0);
    @(posedge clk); @(negedge clk);
    chk("btn_irq", {31'h0, bus.irq}, 32'h1);
    host_wr(5'd3, 32'h4);
    @(posedge clk); @(negedge clk);
    chk("w1c_irq", {31'h0, bus.irq}, 32'h0);
    button(1'b0);
    @(negedge clk);
    enc[2] = 1'b1;
    repeat (SS) @(posedge clk);
    @(negedge clk);
    bus.cs = 1'b1; bus.write = 1'b1; bus.addr = 5'd3; bus.wr_data = 32'h4;
    @(negedge clk);
    bus.cs = 1'b0; bus.write = 1'b0; bus.wr_data = 32'h0;
    m_status[2] = 1'b1; m_btn = 1'b1;
    check_all("w1c_vs_set");

    // Unmapped and unused bits.
    host_wr(5'd5, 32'hFFFF_FFFF);
    bus_rd(5'd5, d); chk("irqen_bits", d, 32'hF);
    host_wr(5'd1, 32'hFFFF_FFF9);
    bus_rd(5'd1, d); chk("ctrl_bits", d, 32'h1);
    bus_rd(5'd17, d); chk("unmapped", d, 32'h0);

    // Randomized mix against the model.
    host_wr(5'd2, 32'd4);
    for (int it = 0; it < 60; it++) begin
      int act;
      act = int'($urandom_range(0, 9));
      case (act)
        0, 1: cw_detent();
        2, 3: ccw_detent();
        4: host_wr(5'd1, 32'($urandom_range(0, 7)));
        5: host_wr(5'd2, 32'($urandom_range(0, 6)));
        6: host_wr(5'd0, 32'($urandom_range(0, 9)));
        7: begin
          if ($urandom_range(0, 1) == 1) host_wr(5'd3, 32'($urandom_range(0, 15)));
          else host_wr(5'd5, 32'($urandom_range(0, 15)));
        end
        8: set_ab(m_ab ^ 2'b11);
        default: begin
          if ($urandom_range(0, 1) == 1) button(~m_btn);
          else switch_set(~enc[3]);
        end
      endcase
      check_all($sformatf("rnd%0d", it));
    end

    // Reset in the middle of a detent discards it.
    button(1'b0);
    switch_set(1'b0);
    set_ab(2'b00);
    set_ab(2'b01); set_ab(2'b11);
    @(negedge clk);
    reset = 1'b0;
    repeat (2) @(posedge clk);
    chk_reset("midrst");
    @(negedge clk);
    reset = 1'b1;
    model_reset();
    repeat (6) @(posedge clk);
    model_ab(2'b11);
    set_ab(2'b10); set_ab(2'b00);
    check_all("post_rst");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/enc_slot_ctrl.md
ENC_SLOT_CTRL -- requirements
Module: enc_slot_ctrl

Interface
REQ-001 SHALL have parameter W, default 16: position counter and limit width (2..31).
REQ-002 SHALL have parameter SYNC_STAGES, default 2: input synchronizer depth (>=2).
REQ-003 SHALL have port clk  input  1  sole clock; all state on rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-low reset (asserted at 0).
REQ-005 SHALL have port cs  input  1  slot select; qualifies write and read.
REQ-006 SHALL have port read  input  1  slot read strobe (no side effects).
REQ-007 SHALL have port write  input  1  slot write strobe; acts when cs=1.
REQ-008 SHALL have port addr  input  5  register select.
REQ-009 SHALL have port wr_data  input  32  write data.
REQ-010 SHALL have port rd_data  output  32  read data, combinational from addr and registers.
REQ-011 SHALL have port enc  input  4  [0]=A, [1]=B, [2]=push button, [3]=slide switch; debounced externally, asynchronous to clk.
REQ-012 SHALL have port irq  output  1  registered OR of (STATUS[3:0] & IRQ_EN[3:0]).

Function
REQ-013 SHALL pass all four enc bits through SYNC_STAGES flip-flops before any use.
REQ-014 SHALL decode synchronized AB with a 4-state Gray FSM; CW order 00->01->11->10->00, CCW the reverse.
REQ-015 SHALL emit one CW step on 10->00 and one CCW step on 01->00 (detent mode); other legal transitions update state only.
REQ-016 SHALL treat a simultaneous change of A and B as illegal: no step, FSM adopts new AB, ERRCNT += 1, saturating at 255.
REQ-017 SHALL swap CW/CCW when CTRL[2] (invert) = 1, and ignore steps (FSM still tracks) when CTRL[0] (enable) = 0.
REQ-018 SHALL update POS the cycle after the decode cycle; latency from enc edge to POS change = SYNC_STAGES+2 clk.
REQ-019 SHALL, in saturate mode (CTRL[1]=0), hold POS at 0 on CCW and at MAX on CW, setting STATUS[3] (limit) on each blocked step.
REQ-020 SHALL, in wrap mode (CTRL[1]=1), go MAX->0 on CW and 0->MAX on CCW, setting STATUS[3] on each wrap.
REQ-021 SHALL set STATUS[0] on each applied CW step, STATUS[1] on each CCW step, STATUS[2] on each synchronized button 0->1 edge.
REQ-022 SHALL expose STATUS[4] = synchronized button level, STATUS[5] = synchronized switch level (read-only).
REQ-023 SHALL map registers: 0 POS (RW, W bits), 1 CTRL (RW, bits [2:0]), 2 MAX (RW, W bits), 3 STATUS (bits [3:0] W1C), 4 ERRCNT (RO, 8 bits; any write clears), 5 IRQ_EN (RW, bits [3:0]); unmapped addresses read 0, unused bits read 0.
REQ-024 SHALL apply writes on the clock edge where cs=1 and write=1; new value visible on rd_data the following cycle.
REQ-025 SHALL give a POS write priority over a same-cycle step (step discarded); written value clamped to MAX if larger.
REQ-026 SHALL, when MAX is written below current POS, load POS with the new MAX on the same edge.
REQ-027 SHALL give a hardware set priority over a same-cycle W1C clear of the same STATUS bit.
REQ-028 SHALL treat MAX=0 as valid: POS fixed at 0, every step sets STATUS[3].

Reset
REQ-029 SHALL, while reset=0, force POS=0, CTRL=3'b001, MAX=2^W-1, STATUS[3:0]=0, ERRCNT=0, IRQ_EN=0, irq=0, synchronizers and FSM to 00.
REQ-030 SHALL discard any in-flight step when reset asserts mid-operation; first step after release requires a full detent cycle from 00.

Verification
REQ-031 SHALL verify: reset release, enc=AB 00, drive 4 CW detents -> POS=4, STATUS=0x01, irq=0.
REQ-032 SHALL verify: MAX=5, POS=5, saturate, 1 CW detent -> POS=5, STATUS[3]=1; set CTRL=3'b011, 1 CW -> POS=0.
REQ-033 SHALL verify: AB 00->11 in one sample -> ERRCNT=1, POS unchanged; 256 more illegal jumps -> ERRCNT=255.
REQ-034 SHALL verify: POS write 0x0009 on the same edge as a CW step -> POS=9; MAX write 3 with POS=9 -> POS=3.
REQ-035 SHALL verify: IRQ_EN=0x4, button press -> STATUS[2]=1, irq=1 one cycle later; W1C 0x4 -> irq=0; W1C coincident with new press -> STATUS[2] stays 1.
REQ-036 SHALL verify: reset pulsed low after 01->11 (mid-detent) -> all registers at reset values; subsequent 11->10->00 produces no step.
